drop_scorer: RTL

- Game-logic stage directly downstream of the action stage. Runs in parallel with the display stage.
- Consumes the GS x GS drop matrix and the one-hot paddle position. Classifies every drop that newly lands in the bottom row as a catch or a miss.
- Maintains a saturating score, a lives counter and a sticky game-over flag.
- Sequenced by the top-level enable/done handshake, in the same way as the input, action and display stages.

---
 rtl/drops_pkg.sv | 23 ++
 rtl/drop_scorer_if.sv | 30 +++
 rtl/drop_tally.sv | 69 ++++++
 rtl/drop_scorer.sv | 94 +++++++++
 4 files changed

// File: rtl/drops_pkg.sv
// Shared constants, state encoding and saturation helper for the drop scoring stage.
package drops_pkg;

    localparam int GS_DEF      = 8;
    localparam int SCORE_W_DEF = 8;
    localparam int LANDING_ROW = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        COUNT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Largest value representable in a w-bit score register.
    function automatic int score_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int SCORE_MAX = (1 << SCORE_W_DEF) - 1;

endpackage

// File: rtl/drop_scorer_if.sv
// Enable/done handshake plus frame inputs and score outputs of the drop scorer.
interface drop_scorer_if
    import drops_pkg::*;
#(
    parameter int GS      = GS_DEF,
    parameter int SCORE_W = SCORE_W_DEF
);
    localparam int CW = $clog2(GS + 1);

    logic                 e_score_i;
    logic [GS*GS-1:0]     matrix_i;
    logic [GS-1:0]        paddle_i;
    logic [SCORE_W-1:0]   score_o;
    logic [3:0]           lives_o;
    logic                 game_over_o;
    logic [CW-1:0]        hits_o;
    logic [CW-1:0]        miss_o;
    logic                 d_score_o;

    modport master (
        output e_score_i, matrix_i, paddle_i,
        input  score_o, lives_o, game_over_o, hits_o, miss_o, d_score_o
    );

    modport slave (
        input  e_score_i, matrix_i, paddle_i,
        output score_o, lives_o, game_over_o, hits_o, miss_o, d_score_o
    );

endinterface

// File: rtl/drop_tally.sv
// Bit-serial classifier: walks the captured landing row one column per cycle,
// counting newly landed drops that meet the paddle (hits) or do not (misses).
module drop_tally
    import drops_pkg::*;
#(
    parameter int GS = GS_DEF,
    parameter int CW = $clog2(GS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start,
    input  logic [GS-1:0] new_row,
    input  logic [GS-1:0] pad,
    output logic          busy,
    output logic          last,
    output logic [CW-1:0] hits,
    output logic [CW-1:0] miss
);
    localparam int IW = (GS > 1) ? $clog2(GS) : 1;

    logic [GS-1:0] new_row_reg;
    logic [GS-1:0] pad_reg;
    logic [GS-1:0] hit_vec;
    logic [GS-1:0] miss_vec;
    logic [IW-1:0] idx_reg;
    logic          busy_reg;
    logic [CW-1:0] hits_reg;
    logic [CW-1:0] miss_reg;

    genvar gi;
    generate
        for (gi = 0; gi < GS; gi++) begin : g_class
            assign hit_vec[gi]  = new_row_reg[gi] &  pad_reg[gi];
            assign miss_vec[gi] = new_row_reg[gi] & ~pad_reg[gi];
        end
    endgenerate

    assign last = busy_reg && (idx_reg == IW'(GS - 1));
    assign busy = busy_reg;
    assign hits = hits_reg;
    assign miss = miss_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            new_row_reg <= '0;
            pad_reg     <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            hits_reg    <= '0;
            miss_reg    <= '0;
        end else if (start) begin
            new_row_reg <= new_row;
            pad_reg     <= pad;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            hits_reg    <= '0;
            miss_reg    <= '0;
        end else if (busy_reg) begin
            hits_reg <= hits_reg + CW'(hit_vec[idx_reg]);
            miss_reg <= miss_reg + CW'(miss_vec[idx_reg]);
            if (last) begin
                busy_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drop_scorer.sv
// Scoring stage: sequences a frame evaluation on enable, detects newly landed
// drops against the previous frame and maintains score, lives and game-over.
module drop_scorer
    import drops_pkg::*;
#(
    parameter int GS      = GS_DEF,
    parameter int LIVES   = 3,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    drop_scorer_if.slave bus
);
    localparam int CW    = $clog2(GS + 1);
    localparam int SUM_W = ((SCORE_W > CW) ? SCORE_W : CW) + 1;

    state_t             state_reg, state_next;
    logic [GS-1:0]      prev_row_reg;
    logic [GS-1:0]      landing_row;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [3:0]         lives_reg, lives_next;
    logic               go_reg;
    logic [CW-1:0]      hits_reg, miss_reg;
    logic [SUM_W-1:0]   score_sum;
    logic               tally_busy, tally_last;
    logic [CW-1:0]      tally_hits, tally_miss;

    assign landing_row = bus.matrix_i[LANDING_ROW*GS +: GS];

    drop_tally #(.GS(GS), .CW(CW)) u_tally (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (state_reg == CAPTURE),
        .new_row (landing_row & ~prev_row_reg),
        .pad     (bus.paddle_i),
        .busy    (tally_busy),
        .last    (tally_last),
        .hits    (tally_hits),
        .miss    (tally_miss)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.e_score_i) state_next = CAPTURE;
            CAPTURE: state_next = COUNT;
            COUNT:   if (tally_last || !tally_busy) state_next = UPDATE;
            UPDATE:  state_next = DONE;
            DONE:    if (!bus.e_score_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Saturating score and floor-at-zero lives for the frame being retired.
    always_comb begin
        score_sum  = SUM_W'(score_reg) + SUM_W'(tally_hits);
        score_next = (score_sum > SUM_W'(score_max(SCORE_W))) ? '1 : SCORE_W'(score_sum);
        lives_next = (int'(tally_miss) >= int'(lives_reg)) ? 4'd0 : lives_reg - 4'(tally_miss);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            prev_row_reg <= '0;
            score_reg    <= '0;
            lives_reg    <= 4'(LIVES);
            go_reg       <= 1'b0;
            hits_reg     <= '0;
            miss_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CAPTURE) begin
                prev_row_reg <= landing_row;
            end
            if (state_reg == UPDATE) begin
                hits_reg <= tally_hits;
                miss_reg <= tally_miss;
                if (!go_reg) begin
                    score_reg <= score_next;
                    lives_reg <= lives_next;
                    go_reg    <= (lives_next == 4'd0);
                end
            end
        end
    end

    assign bus.score_o     = score_reg;
    assign bus.lives_o     = lives_reg;
    assign bus.game_over_o = go_reg;
    assign bus.hits_o      = hits_reg;
    assign bus.miss_o      = miss_reg;
    assign bus.d_score_o   = (state_reg == DONE);

endmodule
